// File: rtl/rv_mem_pkg.sv
// Shared memory-stage types: funct3 codes, FSM states,
// EX/MEM control bundle and access-size helpers.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } mem_size_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  // Reserved encodings fall through to a word access.
  function automatic mem_size_e access_size(
    input logic [2:0] f3
  );
    mem_size_e sz;
    unique case (1'b1)
      (f3 == F3_B) || (f3 == F3_BU): sz = SZ_B;
      (f3 == F3_H) || (f3 == F3_HU): sz = SZ_H;
      default:                       sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic m;
    unique case (access_size(f3))
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load extractor: picks byte/half lane from a raw word
// and sign- or zero-extends it to XLEN.
module mem_load_align
  import rv_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        uns;
  mem_size_e   sz;

  assign b   = rdata[8*addr +: 8];
  assign h   = rdata[16*addr[1] +: 16];
  assign uns = funct3[2];
  assign sz  = access_size(funct3);

  always_comb begin
    data = rdata;
    unique case (sz)
      SZ_B: data = {{(XLEN-8){b[7] & ~uns}}, b};
      SZ_H: data = {{(XLEN-16){h[15] & ~uns}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: issues dmem requests for loads
// and stores, stalls upstream, registers writeback result.
module mem_stage_ctrl
  import rv_mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [4:0]        ex_rd,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              exc_misalign
);

  mem_state_e      state;
  mem_state_e      state_nx;
  mem_ctrl_t       ctrl_in;
  mem_ctrl_t       ctrl_q;
  logic [2:0]      f3_q;
  logic [1:0]      alo_q;
  logic [XLEN-1:0] alu_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] ld_data;

  logic            is_mem;
  logic            mis;
  logic            acc_pass;
  logic            acc_mis;
  logic            acc_mem;
  logic            rsp_done;
  logic [3:0]      strb_nx;
  logic [XLEN-1:0] wdata_nx;

  assign ctrl_in = '{
    mem_read:   ex_mem_read,
    mem_write:  ex_mem_write,
    mem_to_reg: ex_mem_to_reg,
    reg_write:  ex_reg_write
  };

  assign is_mem = ex_mem_read | ex_mem_write;
  assign mis    = misaligned(ex_funct3, ex_alu_result[1:0]);

  assign ex_ready       = (state == IDLE);
  assign dmem_req_valid = (state == REQ);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    acc_pass = 1'b0;
    acc_mis  = 1'b0;
    acc_mem  = 1'b0;
    rsp_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (ex_valid) begin
          unique case (1'b1)
            !is_mem:        acc_pass = 1'b1;
            is_mem && mis:  acc_mis  = 1'b1;
            is_mem && !mis: begin
              acc_mem  = 1'b1;
              state_nx = REQ;
            end
            default: ;
          endcase
        end
      end
      REQ: begin
        if (dmem_req_ready) state_nx = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          rsp_done = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lane placement for stores; loads drive no byte enables.
  always_comb begin
    strb_nx  = 4'b0000;
    wdata_nx = ex_store_data;
    unique case (access_size(ex_funct3))
      SZ_B: begin
        strb_nx  = 4'b0001 << ex_alu_result[1:0];
        wdata_nx = {(XLEN/8){ex_store_data[7:0]}};
      end
      SZ_H: begin
        strb_nx  = 4'b0011 << ex_alu_result[1:0];
        wdata_nx = {(XLEN/16){ex_store_data[15:0]}};
      end
      default: strb_nx = 4'b1111;
    endcase
    if (!ex_mem_write) strb_nx = 4'b0000;
  end

  mem_load_align #(
    .XLEN (XLEN)
  ) u_align (
    .rdata  (dmem_rdata),
    .addr   (alo_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      f3_q         <= '0;
      alo_q        <= '0;
      alu_q        <= '0;
      rd_q         <= '0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wstrb   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      exc_misalign <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      exc_misalign <= 1'b0;
      if (acc_pass) begin
        wb_valid     <= 1'b1;
        wb_reg_write <= ex_reg_write;
        wb_rd        <= ex_rd;
        wb_data      <= ex_alu_result;
      end
      if (acc_mis) begin
        wb_valid     <= 1'b1;
        wb_rd        <= ex_rd;
        wb_data      <= ex_alu_result;
        exc_misalign <= 1'b1;
      end
      if (acc_mem) begin
        ctrl_q     <= ctrl_in;
        f3_q       <= ex_funct3;
        alo_q      <= ex_alu_result[1:0];
        alu_q      <= ex_alu_result;
        rd_q       <= ex_rd;
        dmem_we    <= ex_mem_write;
        dmem_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
        dmem_wdata <= wdata_nx;
        dmem_wstrb <= strb_nx;
      end
      if (rsp_done) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
        if (ctrl_q.mem_write) begin
          wb_data <= alu_q;
        end else begin
          wb_reg_write <= ctrl_q.reg_write;
          wb_data      <= ctrl_q.mem_to_reg ? ld_data : alu_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: passthrough, loads,
// stores with backpressure, misalignment and reset abort.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misalign;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .XLEN   (32),
    .ADDR_W (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_reg_write   (ex_reg_write),
    .ex_funct3      (ex_funct3),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .exc_misalign   (exc_misalign)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        rd_en,
    input logic        wr_en,
    input logic        m2r,
    input logic        rw,
    input logic [2:0]  f3,
    input logic [31:0] alu,
    input logic [31:0] sd,
    input logic [4:0]  rd
  );
    ex_valid      = 1'b1;
    ex_mem_read   = rd_en;
    ex_mem_write  = wr_en;
    ex_mem_to_reg = m2r;
    ex_reg_write  = rw;
    ex_funct3     = f3;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_rd         = rd;
  endtask

  task automatic idle_ex();
    ex_valid      = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_mem_to_reg = 1'b0;
    ex_reg_write  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_ex();
    ex_funct3      = 3'b000;
    ex_alu_result  = '0;
    ex_store_data  = '0;
    ex_rd          = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = '0;
    step();
    step();
    n_chk++;
    if (ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ex_ready got %b want 1", ex_ready);
    end
    n_chk++;
    if ({dmem_req_valid, dmem_we, wb_valid,
         wb_reg_write, exc_misalign} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b%b%b%b%b want 00000",
               dmem_req_valid, dmem_we, wb_valid,
               wb_reg_write, exc_misalign);
    end
    n_chk++;
    if ({dmem_addr, dmem_wdata, dmem_wstrb,
         wb_rd, wb_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h %h %h want 0",
               dmem_addr, dmem_wdata, dmem_wstrb, wb_rd, wb_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_passthrough();
    drive(0, 0, 0, 1, 3'b000, 32'h0000_1234, '0, 5'd5);
    step();
    n_chk++;
    if ({wb_valid, wb_reg_write, wb_rd, wb_data} !==
        {1'b1, 1'b1, 5'd5, 32'h0000_1234}) begin
      n_fail++;
      $display("FAIL add_wb got v=%b rw=%b rd=%0d d=%h want 1 1 5 00001234",
               wb_valid, wb_reg_write, wb_rd, wb_data);
    end
    n_chk++;
    if (dmem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_noreq got %b want 0", dmem_req_valid);
    end
    drive(0, 0, 0, 0, 3'b000, 32'hCAFE_0001, '0, 5'd9);
    step();
    n_chk++;
    if ({wb_valid, wb_reg_write, wb_rd, wb_data} !==
        {1'b1, 1'b0, 5'd9, 32'hCAFE_0001}) begin
      n_fail++;
      $display("FAIL b2b_wb got v=%b rw=%b rd=%0d d=%h want 1 0 9 cafe0001",
               wb_valid, wb_reg_write, wb_rd, wb_data);
    end
    idle_ex();
    step();
    n_chk++;
    if (wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_pulse got %b want 0", wb_valid);
    end
  endtask

  task automatic do_load(
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] raw,
    input logic [31:0] exp_addr,
    input logic [31:0] exp_data,
    input string       name
  );
    dmem_req_ready = 1'b1;
    drive(1, 0, 1, 1, f3, addr, '0, 5'd7);
    step();
    idle_ex();
    n_chk++;
    if ({dmem_req_valid, dmem_we, ex_ready, dmem_addr} !==
        {1'b1, 1'b0, 1'b0, exp_addr}) begin
      n_fail++;
      $display("FAIL %s_req got v=%b we=%b rdy=%b a=%h want 1 0 0 %h",
               name, dmem_req_valid, dmem_we, ex_ready,
               dmem_addr, exp_addr);
    end
    step();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = raw;
    step();
    dmem_rsp_valid = 1'b0;
    n_chk++;
    if ({wb_valid, wb_reg_write, wb_rd, wb_data} !==
        {1'b1, 1'b1, 5'd7, exp_data}) begin
      n_fail++;
      $display("FAIL %s_wb got v=%b rw=%b rd=%0d d=%h want 1 1 7 %h",
               name, wb_valid, wb_reg_write, wb_rd, wb_data, exp_data);
    end
  endtask

  task automatic test_loads();
    do_load(3'b000, 32'h0000_1003, 32'h80FF_7F01,
            32'h0000_1000, 32'hFFFF_FF80, "lb");
    do_load(3'b100, 32'h0000_1003, 32'h80FF_7F01,
            32'h0000_1000, 32'h0000_0080, "lbu");
    do_load(3'b001, 32'h0000_1002, 32'h80FF_7F01,
            32'h0000_1000, 32'hFFFF_80FF, "lh");
    do_load(3'b101, 32'h0000_1000, 32'h80FF_F701,
            32'h0000_1000, 32'h0000_F701, "lhu");
    do_load(3'b010, 32'h0000_1004, 32'h1357_9BDF,
            32'h0000_1004, 32'h1357_9BDF, "lw");
  endtask

  task automatic test_store_backpressure();
    dmem_req_ready = 1'b0;
    drive(0, 1, 0, 1, 3'b001, 32'h0000_2002,
          32'hDEAD_BEEF, 5'd3);
    step();
    idle_ex();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({dmem_req_valid, dmem_we, ex_ready, dmem_addr,
           dmem_wdata, dmem_wstrb} !==
          {1'b1, 1'b1, 1'b0, 32'h0000_2000,
           32'hBEEF_BEEF, 4'b1100}) begin
        n_fail++;
        $display("FAIL sh_hold%0d got v=%b we=%b rdy=%b a=%h d=%h s=%b",
                 i, dmem_req_valid, dmem_we, ex_ready,
                 dmem_addr, dmem_wdata, dmem_wstrb);
      end
      step();
    end
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    n_chk++;
    if ({dmem_req_valid, ex_ready, wb_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL sh_wait got v=%b rdy=%b wb=%b want 000",
               dmem_req_valid, ex_ready, wb_valid);
    end
    dmem_rsp_valid = 1'b1;
    step();
    dmem_rsp_valid = 1'b0;
    n_chk++;
    if ({wb_valid, wb_reg_write, ex_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL sh_ack got v=%b rw=%b rdy=%b want 1 0 1",
               wb_valid, wb_reg_write, ex_ready);
    end
  endtask

  task automatic test_store_lanes();
    dmem_req_ready = 1'b0;
    drive(0, 1, 0, 0, 3'b000, 32'h0000_4001,
          32'h0000_00A5, 5'd0);
    step();
    idle_ex();
    n_chk++;
    if ({dmem_wstrb, dmem_wdata, dmem_addr} !==
        {4'b0010, 32'hA5A5_A5A5, 32'h0000_4000}) begin
      n_fail++;
      $display("FAIL sb_lane got s=%b d=%h a=%h want 0010 a5a5a5a5 4000",
               dmem_wstrb, dmem_wdata, dmem_addr);
    end
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    step();
    dmem_rsp_valid = 1'b0;
    drive(1, 1, 0, 1, 3'b010, 32'h0000_4008,
          32'h0123_4567, 5'd1);
    step();
    idle_ex();
    n_chk++;
    if ({dmem_we, dmem_wstrb, dmem_wdata} !==
        {1'b1, 4'b1111, 32'h0123_4567}) begin
      n_fail++;
      $display("FAIL sw_both got we=%b s=%b d=%h want 1 1111 01234567",
               dmem_we, dmem_wstrb, dmem_wdata);
    end
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    step();
    dmem_rsp_valid = 1'b0;
    n_chk++;
    if ({wb_valid, wb_reg_write} !== 2'b10) begin
      n_fail++;
      $display("FAIL sw_both_wb got v=%b rw=%b want 1 0",
               wb_valid, wb_reg_write);
    end
  endtask

  task automatic test_misalign();
    drive(1, 0, 1, 1, 3'b010, 32'h0000_3002, '0, 5'd4);
    n_chk++;
    if (dmem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_noreq0 got %b want 0", dmem_req_valid);
    end
    step();
    idle_ex();
    n_chk++;
    if ({exc_misalign, wb_valid, wb_reg_write,
         dmem_req_valid, ex_ready} !== 5'b11001) begin
      n_fail++;
      $display("FAIL mis_wb got e=%b v=%b rw=%b rq=%b rdy=%b want 11001",
               exc_misalign, wb_valid, wb_reg_write,
               dmem_req_valid, ex_ready);
    end
    drive(1, 0, 1, 1, 3'b001, 32'h0000_3001, '0, 5'd4);
    step();
    idle_ex();
    n_chk++;
    if ({exc_misalign, dmem_req_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL mis_lh got e=%b rq=%b want 1 0",
               exc_misalign, dmem_req_valid);
    end
    step();
    n_chk++;
    if ({exc_misalign, wb_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL mis_pulse got e=%b v=%b want 00",
               exc_misalign, wb_valid);
    end
  endtask

  task automatic test_reset_abort();
    dmem_req_ready = 1'b1;
    drive(1, 0, 1, 1, 3'b010, 32'h0000_3000, '0, 5'd6);
    step();
    idle_ex();
    step();
    dmem_req_ready = 1'b0;
    n_chk++;
    if ({ex_ready, dmem_req_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_wait got rdy=%b rq=%b want 00",
               ex_ready, dmem_req_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if ({ex_ready, dmem_req_valid, wb_valid, wb_data} !==
        {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL abort_rst got rdy=%b rq=%b v=%b d=%h want 1 0 0 0",
               ex_ready, dmem_req_valid, wb_valid, wb_data);
    end
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'h5555_AAAA;
    step();
    dmem_rsp_valid = 1'b0;
    n_chk++;
    if ({wb_valid, ex_ready, wb_data} !==
        {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL abort_stray got v=%b rdy=%b d=%h want 0 1 0",
               wb_valid, ex_ready, wb_data);
    end
    dmem_req_ready = 1'b0;
    drive(0, 1, 0, 0, 3'b010, 32'h0000_5000, '0, 5'd0);
    step();
    idle_ex();
    n_chk++;
    if (dmem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL req_abort_pre got %b want 1", dmem_req_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if ({dmem_req_valid, ex_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL req_abort got rq=%b rdy=%b want 0 1",
               dmem_req_valid, ex_ready);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_loads();
    test_store_backpressure();
    test_store_lanes();
    test_misalign();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage sequencer that consumes the decoded control bits (memRead, memWrite, memToReg, regWrite) carried in the EX/MEM pipeline register.
- Turns loads and stores into a valid/ready request plus response transaction on the data-memory port.
- Stalls the upstream pipeline while a transaction is outstanding.
- Delivers a registered, aligned and extended result to writeback.
- Non-memory instructions pass through to writeback with one cycle of latency.

Parameters:
XLEN, 32, data path and register width
ADDR_W, 32, data-memory address width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
ex_valid  in  1  EX/MEM holds an instruction
ex_ready  out  1  stage can accept; low = upstream stall
ex_mem_read  in  1  load (memRead)
ex_mem_write  in  1  store (memWrite)
ex_mem_to_reg  in  1  writeback selects memory data
ex_reg_write  in  1  instruction writes rd
ex_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
ex_alu_result  in  XLEN  effective address or ALU result
ex_store_data  in  XLEN  rs2 value for stores
ex_rd  in  5  destination register
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
dmem_wdata  out  XLEN  lane-replicated store data
dmem_wstrb  out  4  byte enables
dmem_rsp_valid  in  1  load data / store ack
dmem_rdata  in  XLEN  raw word read
wb_valid  out  1  writeback entry valid, one-cycle pulse
wb_reg_write  out  1  write rd
wb_rd  out  5  destination register
wb_data  out  XLEN  result (memory data if memToReg, else ALU result)
exc_misalign  out  1  misaligned access, one-cycle pulse with wb_valid

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE; ex_ready = 1.
  - dmem_req_valid, dmem_we, wb_valid, wb_reg_write, exc_misalign = 0.
  - dmem_addr, dmem_wdata, dmem_wstrb, wb_rd, wb_data = 0.
- Reset mid-transaction:
  - Any outstanding request is abandoned; dmem_req_valid drops in the cycle after rst is sampled.
  - A later dmem_rsp_valid is ignored in IDLE.
- States are IDLE, REQ and WAIT_RSP. ex_ready = (state == IDLE).
- IDLE, accept when ex_valid = 1:
  - Non-memory (mem_read = mem_write = 0): next cycle wb_valid = 1, wb_data = alu_result, wb_reg_write = reg_write; stay IDLE. Back-to-back accepts are allowed.
  - Misaligned access (H with addr[0] = 1, W with addr[1:0] != 0): no request. Next cycle wb_valid = 1, wb_reg_write = 0, exc_misalign = 1; stay IDLE.
  - Aligned load or store: latch the request fields and go to REQ. mem_read and mem_write both set is treated as a store.
- REQ:
  - dmem_req_valid = 1; addr, we, wdata and wstrb are held stable until dmem_req_ready.
  - On dmem_req_ready, go to WAIT_RSP.
  - dmem_rsp_valid is ignored in REQ.
- WAIT_RSP:
  - On dmem_rsp_valid, go to IDLE. Next cycle wb_valid = 1.
  - Load: wb_data = aligned and extended rdata, wb_reg_write = latched reg_write.
  - Store: wb_reg_write = 0.
- Minimum load/store latency, accept to wb_valid: 3 cycles (ready and response each arriving immediately).
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0], byte replicated ×4.
  - SH: wstrb = 0011 << addr[1:0], half replicated ×2.
  - SW: wstrb = 1111.
- Load extract: byte/half selected by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Reserved funct3 on a memory op is treated as W.

Decomposition:
- Shared package rv_mem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE, REQ, WAIT_RSP);
  - a struct bundling the EX/MEM control bits, also used by the decoder and the pipeline register.
- One combinational sub-module, mem_load_align (rdata, addr[1:0], funct3 -> extended XLEN word), reused by the writeback/forwarding path.

Test Plan:
- ADD passthrough: alu_result = 0x0000_1234, reg_write = 1, rd = 5 -> next cycle wb_valid = 1, wb_data = 0x1234, wb_rd = 5, no dmem request.
- LB at 0x1003, rdata = 0x80FF_7F01, ready and response immediate -> dmem_addr = 0x1000, wb_data = 0xFFFF_FF80; repeat with LBU -> 0x0000_0080.
- SH at 0x2002, store_data = 0xDEAD_BEEF, req_ready held low 4 cycles:
  - dmem_req_valid, addr, wdata and wstrb stable throughout;
  - dmem_wstrb = 1100, dmem_wdata = 0xBEEF_BEEF;
  - ex_ready stays 0;
  - wb_valid = 1 with wb_reg_write = 0 after the ack.
- LW at 0x3002 -> no dmem_req_valid; next cycle exc_misalign = 1, wb_valid = 1, wb_reg_write = 0.
- LW in WAIT_RSP, assert rst for one cycle, then a stray dmem_rsp_valid -> state IDLE, ex_ready = 1, no wb_valid, stray response ignored.
